// File: rtl/jt12_acc_hd.sv
// Carrier accumulator for the high-precision FM operator stream: sums the carrier operators
// of each channel per algorithm, emits saturated per-channel samples and a per-round mix.
module jt12_acc_hd #(
  parameter int unsigned num_ch = 6,
  parameter int unsigned win    = 14,
  parameter int unsigned wout   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic signed [win-1:0]  op_result,
  input  logic                   s1_enters,
  input  logic                   s2_enters,
  input  logic                   s3_enters,
  input  logic                   s4_enters,
  input  logic                   zero,
  input  logic [2:0]             alg,
  input  logic [num_ch-1:0]      ch_en,
  output logic signed [wout-1:0] snd,
  output logic [2:0]             snd_ch,
  output logic                   snd_valid,
  output logic signed [wout-1:0] mix,
  output logic                   mix_valid
);

  localparam int unsigned AW = win + 2;
  localparam int unsigned EW = win + 4;
  localparam int unsigned MW = wout + 3;

  localparam logic signed [EW-1:0] SndMax = EW'((64'd1 << (wout - 1)) - 64'd1);
  localparam logic signed [EW-1:0] SndMin = -SndMax - EW'(1);
  localparam logic signed [MW-1:0] MixMax = MW'((64'd1 << (wout - 1)) - 64'd1);
  localparam logic signed [MW-1:0] MixMin = -MixMax - MW'(1);

  typedef enum logic [2:0] {SlotNone, SlotS1, SlotS3, SlotS2, SlotS4} slot_e;

  slot_e                  slot;
  logic [2:0]             cnt_q, cnt_d, ch;
  logic                   ch_last, carrier;
  logic signed [AW-1:0]   acc_q [num_ch];
  logic signed [AW-1:0]   term, head, total, acc_in;
  logic signed [EW-1:0]   total_ext;
  logic signed [wout-1:0] snd_sat, mix_sat;
  logic signed [MW-1:0]   mix_sum_q, mix_tot;

  always_comb begin
    slot = SlotNone;
    if (s1_enters)      slot = SlotS1;
    else if (s3_enters) slot = SlotS3;
    else if (s2_enters) slot = SlotS2;
    else if (s4_enters) slot = SlotS4;

    ch      = zero ? 3'd0 : cnt_q;
    ch_last = (ch == 3'(num_ch - 1));
    cnt_d   = zero ? 3'd1 : ((cnt_q == 3'(num_ch - 1)) ? 3'd0 : cnt_q + 3'd1);

    case (slot)
      SlotS1:  carrier = (alg == 3'd7);
      SlotS3:  carrier = (alg >= 3'd5);
      SlotS2:  carrier = (alg >= 3'd4);
      SlotS4:  carrier = 1'b1;
      default: carrier = 1'b0;
    endcase
    if (!ch_en[ch]) carrier = 1'b0;

    term  = carrier ? {{2{op_result[win-1]}}, op_result} : '0;
    // Head of the ring is the entry of the channel in the current slot
    head  = acc_q[num_ch-1];
    total = head + term;

    case (slot)
      SlotS1:         acc_in = term;
      SlotS3, SlotS2: acc_in = total;
      default:        acc_in = head;
    endcase

    total_ext = {{2{total[AW-1]}}, total};
    if (total_ext > SndMax)      snd_sat = SndMax[wout-1:0];
    else if (total_ext < SndMin) snd_sat = SndMin[wout-1:0];
    else                         snd_sat = total_ext[wout-1:0];

    mix_tot = mix_sum_q + {{3{snd_sat[wout-1]}}, snd_sat};
    if (mix_tot > MixMax)      mix_sat = MixMax[wout-1:0];
    else if (mix_tot < MixMin) mix_sat = MixMin[wout-1:0];
    else                       mix_sat = mix_tot[wout-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      for (int i = 0; i < int'(num_ch); i++) acc_q[i] <= '0;
      snd       <= '0;
      snd_ch    <= '0;
      snd_valid <= 1'b0;
      mix       <= '0;
      mix_valid <= 1'b0;
      mix_sum_q <= '0;
    end else begin
      snd_valid <= 1'b0;
      mix_valid <= 1'b0;
      if (clk_en) begin
        cnt_q    <= cnt_d;
        acc_q[0] <= acc_in;
        for (int i = 1; i < int'(num_ch); i++) acc_q[i] <= acc_q[i-1];
        if (slot == SlotS4) begin
          snd       <= snd_sat;
          snd_ch    <= ch;
          snd_valid <= 1'b1;
          if (ch_last) begin
            mix       <= mix_sat;
            mix_valid <= 1'b1;
            mix_sum_q <= '0;
          end else begin
            mix_sum_q <= mix_tot;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_acc_hd.sv
// Scoreboard bench for jt12_acc_hd: expected samples and mixes are queued as S4 slots are
// driven and compared when the strobes appear.
module tb_jt12_acc_hd;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_en;
  logic signed [13:0] op_result;
  logic               s1_enters, s2_enters, s3_enters, s4_enters;
  logic               zero;
  logic [2:0]         alg;
  logic [5:0]         ch_en;
  logic signed [13:0] snd;
  logic [2:0]         snd_ch;
  logic               snd_valid;
  logic signed [13:0] mix;
  logic               mix_valid;

  int n_checks = 0;
  int n_fails  = 0;
  int snd_q[$];
  int ch_q[$];
  int mix_q[$];
  int o1[6], o3[6], o2[6], o4[6];

  jt12_acc_hd #(.num_ch(6), .win(14), .wout(14)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .op_result (op_result),
    .s1_enters (s1_enters),
    .s2_enters (s2_enters),
    .s3_enters (s3_enters),
    .s4_enters (s4_enters),
    .zero      (zero),
    .alg       (alg),
    .ch_en     (ch_en),
    .snd       (snd),
    .snd_ch    (snd_ch),
    .snd_valid (snd_valid),
    .mix       (mix),
    .mix_valid (mix_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat14(input int x);
    if (x > 8191)  return 8191;
    if (x < -8192) return -8192;
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && snd_valid === 1'b1) begin
      if (snd_q.size() == 0) check_eq("snd_unexpected_strobe", 1, 0);
      else begin
        check_eq("snd", int'(snd), snd_q.pop_front());
        check_eq("snd_ch", int'(snd_ch), ch_q.pop_front());
      end
    end
    if (rst === 1'b1 && mix_valid === 1'b1) begin
      if (mix_q.size() == 0) check_eq("mix_unexpected_strobe", 1, 0);
      else check_eq("mix", int'(mix), mix_q.pop_front());
    end
  end

  task automatic randomize_inputs();
    op_result = 14'($urandom);
    {s1_enters, s2_enters, s3_enters, s4_enters} = 4'($urandom);
    zero  = 1'($urandom);
    alg   = 3'($urandom);
  endtask

  task automatic fill(input int v1, input int v3, input int v2, input int v4, input int step);
    for (int c = 0; c < 6; c++) begin
      o1[c] = v1 + step * c;
      o3[c] = v3 + step * c;
      o2[c] = v2 + step * c;
      o4[c] = v4 + step * c;
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < 6; c++) begin
      o1[c] = int'($urandom_range(0, 16383)) - 8192;
      o3[c] = int'($urandom_range(0, 16383)) - 8192;
      o2[c] = int'($urandom_range(0, 16383)) - 8192;
      o4[c] = int'($urandom_range(0, 16383)) - 8192;
    end
  endtask

  // Drives one full round S1, S3, S2, S4 x six channels; stall inserts 3 idle cycles per slot
  task automatic run_round(input logic [2:0] a, input logic [5:0] en, input bit stall);
    int mix_acc = 0;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 6; c++) begin
        clk_en    = 1'b1;
        alg       = a;
        ch_en     = en;
        zero      = (g == 0 && c == 0);
        s1_enters = (g == 0);
        s3_enters = (g == 1);
        s2_enters = (g == 2);
        s4_enters = (g == 3);
        case (g)
          0:       op_result = 14'(o1[c]);
          1:       op_result = 14'(o3[c]);
          2:       op_result = 14'(o2[c]);
          default: op_result = 14'(o4[c]);
        endcase
        if (g == 3) begin
          int s = 0;
          if (en[c]) begin
            if (a == 3'd7) s += o1[c];
            if (a >= 3'd5) s += o3[c];
            if (a >= 3'd4) s += o2[c];
            s += o4[c];
          end
          s = sat14(s);
          snd_q.push_back(s);
          ch_q.push_back(c);
          mix_acc += s;
          if (c == 5) mix_q.push_back(sat14(mix_acc));
        end
        @(posedge clk); #1;
        if (stall) begin
          clk_en = 1'b0;
          repeat (3) begin
            randomize_inputs();
            @(posedge clk); #1;
          end
        end
      end
    end
    clk_en = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    clk_en = 1'b1;
    ch_en  = 6'h3f;
    repeat (3) begin
      randomize_inputs();
      ch_en = 6'($urandom);
      @(posedge clk); #1;
    end
    check_eq("rst_snd", int'(snd), 0);
    check_eq("rst_mix", int'(mix), 0);
    check_eq("rst_snd_valid", int'(snd_valid), 0);
    check_eq("rst_mix_valid", int'(mix_valid), 0);
    check_eq("rst_snd_ch", int'(snd_ch), 0);
    rst    = 1'b1;
    clk_en = 1'b0;
    @(posedge clk); #1;

    fill(100, 200, -50, 25, 0);     run_round(3'd7, 6'h3f, 1'b0);
    fill(100, 200, -50, 25, 0);     run_round(3'd0, 6'h3f, 1'b0);
    fill(100, 200, -50, 25, 0);     run_round(3'd4, 6'h3f, 1'b0);
    fill(8191, 8191, 8191, 8191, 0);     run_round(3'd7, 6'h3f, 1'b0);
    fill(-8192, -8192, -8192, -8192, 0); run_round(3'd7, 6'h3f, 1'b0);
    fill(10, 10, 10, 10, 0);        run_round(3'd7, 6'h3e, 1'b0);
    fill(30, -20, 40, 5, 3);        run_round(3'd5, 6'h3f, 1'b0);

    // Mid-round resync: three S1 slots move the counter to 3, then zero restarts the round
    for (int c = 0; c < 3; c++) begin
      clk_en = 1'b1; zero = 1'b0; alg = 3'd7; ch_en = 6'h3f;
      {s1_enters, s3_enters, s2_enters, s4_enters} = 4'b1000;
      op_result = 14'(500);
      @(posedge clk); #1;
    end
    fill(100, 200, -50, 25, 1);     run_round(3'd7, 6'h3f, 1'b0);

    fill(7, 11, -13, 17, 7);        run_round(3'd7, 6'h3f, 1'b1);
    fill_random();                  run_round(3'd6, 6'h3f, 1'b0);
    fill_random();                  run_round(3'd7, 6'($urandom), 1'b1);

    for (int i = 0; i < 20 && (snd_q.size() != 0 || mix_q.size() != 0); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check_eq("snd_queue_drained", snd_q.size(), 0);
    check_eq("mix_queue_drained", mix_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
